// File: rtl/seq_bit_serializer_pkg.sv
// Shared definitions for the bit serializer: state encoding and counter sizing.
package seq_bit_serializer_pkg;

  // State encodings are fixed so the detector bench can decode them.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10
  } state_t;

  // Bit-counter width for a given word width (room for data bits plus parity).
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// WIDTH-bit load / shift-left register; msb is the bit that leaves next.
module ser_shift_reg #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             msb
);

  logic [WIDTH-1:0] q;

  // Load has priority over shift; zeros enter at the LSB.
  always_ff @(posedge clk) begin
    // NOTE: this register is reset even though it holds datapath bits, so a
    // reset mid-frame leaves no stale word behind to leak onto bit_out.
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the pattern detector: accepts a word over
// valid/ready and emits it MSB-first with framing strobes and an optional
// idle gap. Define SER_PARITY_EN to append an even-parity bit to each frame.
module seq_bit_serializer
  import seq_bit_serializer_pkg::*;
#(
  parameter int WIDTH      = 20,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             word_start,
  output logic             word_last,
  output logic             busy,
  output logic [15:0]      word_count
);

  localparam int CNT_W = cnt_width(WIDTH);
`ifdef SER_PARITY_EN
  localparam int FL = WIDTH + 1;
  // Bit index at which the parity bit is emitted.
  localparam logic [CNT_W-1:0] PAR_IDX = CNT_W'(WIDTH);
`else
  localparam int FL = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [7:0]       GAP_LAST = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t           state, state_d;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_d, nxt_cnt;
  logic [7:0]       gap_cnt, gap_cnt_d;
  logic             last_bit, accept, load, shift, count_inc;
  logic             bit_out_d, bit_valid_d, word_start_d, word_last_d;
  logic             sreg_msb;
  logic [WIDTH-1:0] load_word;
`ifdef SER_PARITY_EN
  logic             par_q;
`endif

  assign last_bit = (state == SHIFT) && (bit_cnt == LAST_IDX);
  assign nxt_cnt  = bit_cnt + CNT_ONE;

  // A new word is only taken when idle, or back-to-back on the last bit
  // when no gap is configured.
  assign in_ready = (state == IDLE) || (!HAS_GAP && last_bit);
  assign accept   = in_valid && in_ready;

  // The first bit goes straight to bit_out on load, so the register keeps
  // only the remaining bits, already shifted once.
  assign load_word = {in_data[WIDTH-2:0], 1'b0};

  ser_shift_reg #(
    .WIDTH (WIDTH)
  ) u_sreg (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .d     (load_word),
    .msb   (sreg_msb)
  );

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d      = state;
    bit_cnt_d    = bit_cnt;
    gap_cnt_d    = gap_cnt;
    load         = 1'b0;
    shift        = 1'b0;
    count_inc    = 1'b0;
    bit_out_d    = 1'b0;
    bit_valid_d  = 1'b0;
    word_start_d = 1'b0;
    word_last_d  = 1'b0;

    unique case (state)
      IDLE: begin
        state_d = IDLE;
      end
      SHIFT: begin
        if (last_bit) begin
          count_inc = 1'b1;
          gap_cnt_d = 8'd0;
          state_d   = HAS_GAP ? GAP : IDLE;
        end else begin
          bit_cnt_d   = nxt_cnt;
          bit_valid_d = 1'b1;
          word_last_d = (nxt_cnt == LAST_IDX);
`ifdef SER_PARITY_EN
          if (nxt_cnt == PAR_IDX) begin
            bit_out_d = par_q;
          end else begin
            bit_out_d = sreg_msb;
            shift     = 1'b1;
          end
`else
          bit_out_d = sreg_msb;
          shift     = 1'b1;
`endif
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // An accepted word starts a frame, from IDLE or back-to-back.
    if (accept) begin
      state_d      = SHIFT;
      bit_cnt_d    = '0;
      load         = 1'b1;
      bit_out_d    = in_data[WIDTH-1];
      bit_valid_d  = 1'b1;
      word_start_d = 1'b1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      gap_cnt    <= 8'd0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      word_start <= 1'b0;
      word_last  <= 1'b0;
      busy       <= 1'b0;
      word_count <= 16'd0;
    end else begin
      state      <= state_d;
      bit_cnt    <= bit_cnt_d;
      gap_cnt    <= gap_cnt_d;
      bit_out    <= bit_out_d;
      bit_valid  <= bit_valid_d;
      word_start <= word_start_d;
      word_last  <= word_last_d;
      busy       <= (state_d != IDLE);
      if (count_inc) begin
        word_count <= word_count + 16'd1;
      end
    end
  end

`ifdef SER_PARITY_EN
  // Even parity of the loaded word, emitted after the data bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      par_q <= 1'b0;
    end else if (load) begin
      par_q <= ^in_data;
    end
  end
`endif

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Self-checking bench for seq_bit_serializer: a GAP_CYCLES=0 instance for
// streaming/reset tests and a GAP_CYCLES=3 instance for the idle-gap test.
module tb_seq_bit_serializer;

  localparam int WIDTH = 20;
  localparam int GAP_G = 3;
`ifdef SER_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance without gap.
  logic [WIDTH-1:0] in_data;
  logic             in_valid, in_ready, bit_out, bit_valid;
  logic             word_start, word_last, busy;
  logic [15:0]      word_count;

  // Instance with a 3-cycle gap.
  logic [WIDTH-1:0] g_in_data;
  logic             g_in_valid, g_in_ready, g_bit_out, g_bit_valid;
  logic             g_word_start, g_word_last, g_busy;
  logic [15:0]      g_word_count;

  seq_bit_serializer #(.WIDTH(WIDTH), .GAP_CYCLES(0)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .bit_out(bit_out), .bit_valid(bit_valid),
    .word_start(word_start), .word_last(word_last), .busy(busy),
    .word_count(word_count)
  );

  seq_bit_serializer #(.WIDTH(WIDTH), .GAP_CYCLES(GAP_G)) dut_gap (
    .clk(clk), .reset(reset), .in_data(g_in_data), .in_valid(g_in_valid),
    .in_ready(g_in_ready), .bit_out(g_bit_out), .bit_valid(g_bit_valid),
    .word_start(g_word_start), .word_last(g_word_last), .busy(g_busy),
    .word_count(g_word_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a frame is the word's bits MSB-first, plus even parity.
  logic [WIDTH-1:0] tx_q[$];
  bit               exp_bits[$];
  bit               obs_bits[$];
  bit               obs_start[$];
  bit               obs_last[$];
  int               exp_count = 0;

  function automatic void push_frame(input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) exp_bits.push_back(w[i]);
`ifdef SER_PARITY_EN
    exp_bits.push_back(^w);
`endif
  endfunction

  // Offers every word in tx_q to the no-gap instance, collects the serial
  // stream and compares it with the model. span = cycles from first to last
  // valid bit.
  task automatic run_stream(input string tag, input bit random_idle, output int span);
    int n     = tx_q.size();
    int idx   = 0;
    int cyc   = 0;
    int quiet = 0;
    int first = -1;
    int last  = -1;
    bit prev_hs = 1'b0;
    bit stray   = 1'b0;
    exp_bits.delete();
    obs_bits.delete();
    obs_start.delete();
    obs_last.delete();
    foreach (tx_q[i]) push_frame(tx_q[i]);
    while ((idx < n || quiet < FL + 4) && cyc < 40 * FL * (n + 1)) begin
      @(negedge clk);
      cyc++;
      if (bit_valid) begin
        obs_bits.push_back(bit_out);
        obs_start.push_back(word_start);
        obs_last.push_back(word_last);
        if (first < 0) first = cyc;
        last  = cyc;
        quiet = 0;
      end else begin
        if (bit_out || word_start || word_last) stray = 1'b1;
        quiet++;
      end
      if (prev_hs) begin
        idx++;
        in_valid = 1'b0;
      end
      if (idx < n && !in_valid && (!random_idle || $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b1;
        in_data  = tx_q[idx];
      end
      prev_hs = in_valid && in_ready;
    end
    in_valid = 1'b0;
    check({tag, "/completed"}, 64'(idx == n && quiet >= FL + 4), 64'd1);
    check({tag, "/nbits"}, 64'(obs_bits.size()), 64'(exp_bits.size()));
    for (int i = 0; i < exp_bits.size(); i++) begin
      if (i < obs_bits.size()) begin
        check({tag, "/bit"}, 64'(obs_bits[i]), 64'(exp_bits[i]));
        check({tag, "/start"}, 64'(obs_start[i]), 64'(i % FL == 0));
        check({tag, "/last"}, 64'(obs_last[i]), 64'(i % FL == FL - 1));
      end
    end
    check({tag, "/idle_quiet"}, 64'(stray), 64'd0);
    exp_count += n;
    check({tag, "/word_count"}, 64'(word_count), 64'(exp_count[15:0]));
    span = (first < 0) ? 0 : last - first + 1;
    tx_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "/in_ready"},   64'(in_ready),     64'd1);
    check({tag, "/busy"},       64'(busy),         64'd0);
    check({tag, "/bit_valid"},  64'(bit_valid),    64'd0);
    check({tag, "/bit_out"},    64'(bit_out),      64'd0);
    check({tag, "/strobes"},    64'({word_start, word_last}), 64'd0);
    check({tag, "/word_count"}, 64'(word_count),   64'd0);
    check({tag, "/g_in_ready"}, 64'(g_in_ready),   64'd1);
    check({tag, "/g_busy"},     64'(g_busy),       64'd0);
    check({tag, "/g_count"},    64'(g_word_count), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int               span;
    int               t;
    logic [WIDTH-1:0] w1, w2;

    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    g_in_valid = 1'b0;
    g_in_data  = '0;

    // Reset for two cycles, then release.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");

    // Directed vector, single valid pulse.
    tx_q.push_back(20'b11101101001001101101);
    run_stream("vec", 1'b0, span);
    check("vec/span", 64'(span), 64'(FL));

    // Back-to-back words with valid held: no bubble between frames.
    tx_q.push_back(20'hFFFFF);
    tx_q.push_back(20'h00000);
    run_stream("b2b", 1'b0, span);
    check("b2b/span", 64'(span), 64'(2 * FL));

    // Parity corner words (odd and even popcount).
    tx_q.push_back(20'h00007);
    tx_q.push_back(20'h00003);
    run_stream("par", 1'b1, span);

    // Random words with random idle between offers.
    for (int i = 0; i < 8; i++) tx_q.push_back(WIDTH'($urandom));
    run_stream("rnd", 1'b1, span);

    // Gap instance: after word_last, three idle cycles, then ready again.
    w1 = WIDTH'($urandom);
    w2 = WIDTH'($urandom);
    @(negedge clk);
    g_in_valid = 1'b1;
    g_in_data  = w1;
    @(negedge clk);
    check("gap/first_start", 64'(g_word_start), 64'd1);
    check("gap/first_msb", 64'(g_bit_out), 64'(w1[WIDTH-1]));
    g_in_data = w2;  // held valid; must be ignored until ready
    t = 0;
    while (!g_word_last && t < FL + 4) begin
      @(negedge clk);
      t++;
    end
    check("gap/last_pos", 64'(t), 64'(FL - 1));
    for (int k = 1; k <= GAP_G; k++) begin
      @(negedge clk);
      check("gap/idle_valid", 64'(g_bit_valid), 64'd0);
      check("gap/idle_ready", 64'(g_in_ready), 64'd0);
      check("gap/idle_busy", 64'(g_busy), 64'd1);
      check("gap/idle_bit", 64'(g_bit_out), 64'd0);
    end
    @(negedge clk);
    check("gap/ready_back", 64'(g_in_ready), 64'd1);
    check("gap/busy_off", 64'(g_busy), 64'd0);
    check("gap/count1", 64'(g_word_count), 64'd1);
    @(negedge clk);
    check("gap/second_start", 64'(g_word_start), 64'd1);
    check("gap/second_msb", 64'(g_bit_out), 64'(w2[WIDTH-1]));
    g_in_valid = 1'b0;
    repeat (FL + GAP_G + 2) @(negedge clk);
    check("gap/count2", 64'(g_word_count), 64'd2);
    check("gap/done_busy", 64'(g_busy), 64'd0);

    // Reset at bit 7 of a frame, with in_valid high during reset.
    w1 = WIDTH'($urandom);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("rst/mid_frame_valid", 64'(bit_valid), 64'd1);
    check("rst/bit7", 64'(bit_out), 64'(w1[WIDTH-7]));
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = ~w1;
    @(negedge clk);
    check_reset_vals("rst1");
    @(negedge clk);
    check_reset_vals("rst2");
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst/no_accept_valid", 64'(bit_valid), 64'd0);
    check("rst/no_accept_busy", 64'(busy), 64'd0);
    exp_count = 0;
    tx_q.push_back(WIDTH'($urandom));
    run_stream("post_rst", 1'b0, span);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
